output_blk_ctrl: RTL and testbench
==================================

OUTPUT_BLK_CTRL -- requirements
Module: output_blk_ctrl

Interface
REQ-001 Parameter PORTNUM, 16, number of output ports; PW = $clog2(PORTNUM).
REQ-002 Parameter BLK_ADDR_WIDTH, 10, block address width.
REQ-003 Parameter LEN_WIDTH, 10, packet length width in bytes.
REQ-004 Parameter TIMES_WIDTH, 4, width of the last-block word count.
REQ-005 Parameter HDR_BYTES, 4, header bytes prepended to each packet in memory.
REQ-006 Parameters BLK_BYTES, 64, and WORD_BYTES, 4, are powers of two; BLK_BYTES/WORD_BYTES <= 2^TIMES_WIDTH.
REQ-007 i_clk  in  1  clock; i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_port  in  PW  destination port of a new packet; i_port_vld  in  1  packet start strobe.
REQ-009 i_blk_addr  in  BLK_ADDR_WIDTH  next block address from the linked list; i_blk_addr_vld  in  1  address strobe.
REQ-010 i_len  in  LEN_WIDTH  packet length from header; i_len_vld  in  1  length strobe.
REQ-011 i_r_done  in  1  reader finished the current block; i_blk_rdy  in  1  reader accepts a block request.
REQ-012 o_port  out  PW, o_port_vld  out  1  port announcement pulse.
REQ-013 o_blk_addr  out  BLK_ADDR_WIDTH, o_blk_addr_vld  out  1, o_blk_first  out  1  block read request.
REQ-014 o_last_blk_vld  out  1, o_last_r_times  out  TIMES_WIDTH  last-block marker and its word count minus one.
REQ-015 o_len_info_vld  out  1, o_single  out  1  length-resolution pulse; o_pkt_done  out  1; o_busy  out  1; o_addr_ovf  out  1; o_len_err  out  1.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 States SHALL be IDLE, PORT, ADDR_WAIT, ISSUE, LEN_WAIT, RD_WAIT, DONE.
REQ-018 IDLE: i_port_vld=1 latches i_port and goes to PORT; i_port_vld in any other state is ignored.
REQ-019 PORT: o_port/o_port_vld pulse for exactly one cycle, the cycle after acceptance; next state ADDR_WAIT.
REQ-020 A one-entry address holder SHALL capture i_blk_addr whenever i_blk_addr_vld=1 and it is empty, in any non-IDLE state; if it is full, the address is dropped and o_addr_ovf pulses one cycle.
REQ-021 ADDR_WAIT -> ISSUE when the holder is valid; the holder empties when the request is accepted.
REQ-022 ISSUE: o_blk_addr_vld SHALL stay high with o_blk_addr stable until sampled with i_blk_rdy=1; then go to LEN_WAIT for the first block, else to RD_WAIT.
REQ-023 o_blk_first=1 only on the first block request of a packet.
REQ-024 Arithmetic SHALL use T = i_len + HDR_BYTES in LEN_WIDTH+1 bits, nblk = ceil(T/BLK_BYTES), and R = T mod BLK_BYTES, with R=0 treated as BLK_BYTES.
REQ-025 last_r_times SHALL equal ceil(R/WORD_BYTES)-1.
REQ-026 LEN_WAIT: on i_len_vld, the block computes nblk and last_r_times, and pulses o_len_info_vld one cycle with o_last_r_times and o_single=(nblk==1); next state RD_WAIT.
REQ-027 i_len=0 SHALL pulse o_len_err alongside o_len_info_vld and be processed as a header-only one-block packet.
REQ-028 A remaining-block counter SHALL load nblk-1 at length resolution and decrement on each accepted non-first request.
REQ-029 On a request issued with counter==1, o_last_blk_vld=1 and o_last_r_times=last_r_times.
REQ-030 On all other cycles, o_last_blk_vld=0 and o_last_r_times=0.
REQ-031 RD_WAIT: i_r_done=1 goes to DONE if counter==0, else to ADDR_WAIT.
REQ-032 DONE: o_pkt_done pulses one cycle; the state returns to IDLE; counter and holder clear.
REQ-033 o_busy=1 in every state except IDLE.
REQ-034 i_r_done and i_len_vld outside RD_WAIT/LEN_WAIT SHALL be ignored.

Reset
REQ-035 While i_rst_n=0, the state SHALL be IDLE and the counter, holder, port register and every output SHALL be 0, taking effect immediately including mid-packet.
REQ-036 After reset release, the first accepted i_port_vld starts a fresh packet with no residue from an aborted one.

Verification
REQ-037 Port 3, addr 0x010, i_len=60 (T=64) -> o_blk_first request 0x010; o_len_info_vld with o_single=1, o_last_r_times=15; after i_r_done, o_pkt_done; no o_last_blk_vld.
REQ-038 i_len=61 (T=65), addrs 0x010, 0x022 -> 2 blocks; the second request has o_last_blk_vld=1 and o_last_r_times=0.
REQ-039 i_len=200 (T=204), 4 blocks -> counter 3,2,1; the fourth request has o_last_r_times=2; o_pkt_done after the 4th i_r_done.
REQ-040 i_blk_rdy low for 5 cycles during ISSUE -> o_blk_addr_vld held 5+1 cycles with o_blk_addr unchanged; a second i_blk_addr_vld while the holder is full -> o_addr_ovf pulse.
REQ-041 i_rst_n low during RD_WAIT of block 2 -> all outputs 0 next cycle; a new packet on port 7 then completes normally.
REQ-042 i_port_vld during a busy packet and i_len=0 -> the strobe is ignored (o_port unchanged); i_len=0 gives o_len_err plus o_last_r_times=0, o_single=1.

Source files
------------

// File: rtl/output_blk_ctrl.sv
// ---------------------------------------------------------------------------
// output_blk_ctrl
//
// This module sequences the block reads for one outgoing packet at a time.
// A packet starts with a port strobe. Block addresses come from the linked
// list, one at a time, through a one-entry holder. The first block request is
// issued before the packet length is known. When the header length arrives,
// the module works out how many blocks follow and how many words are valid in
// the last block. It flags the last block request with that word count.
//
// Ports
//   i_clk, i_rst_n                   clock, asynchronous active-low reset
//   i_port / i_port_vld              destination port and packet start strobe
//   i_blk_addr / i_blk_addr_vld      next block address from the linked list
//   i_len / i_len_vld                packet length (bytes) from the header
//   i_r_done                         reader finished the current block
//   i_blk_rdy                        reader accepts the pending block request
//   o_port / o_port_vld              one-cycle port announcement
//   o_blk_addr / o_blk_addr_vld      block read request, held until accepted
//   o_blk_first                      request is the first block of the packet
//   o_last_blk_vld / o_last_r_times  last-block marker, valid words minus one
//   o_len_info_vld / o_single        length resolved; packet fits one block
//   o_len_err                        zero-length packet seen
//   o_pkt_done                       packet finished (one-cycle pulse)
//   o_busy                           a packet is in flight
//   o_addr_ovf                       address dropped because holder was full
// ---------------------------------------------------------------------------
module output_blk_ctrl #(
    parameter int PORTNUM        = 16,
    parameter int BLK_ADDR_WIDTH = 10,
    parameter int LEN_WIDTH      = 10,
    parameter int TIMES_WIDTH    = 4,
    parameter int HDR_BYTES      = 4,
    parameter int BLK_BYTES      = 64,
    parameter int WORD_BYTES     = 4,
    localparam int PW            = $clog2(PORTNUM)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [PW-1:0]             i_port,
    input  logic                      i_port_vld,
    input  logic [BLK_ADDR_WIDTH-1:0] i_blk_addr,
    input  logic                      i_blk_addr_vld,
    input  logic [LEN_WIDTH-1:0]      i_len,
    input  logic                      i_len_vld,
    input  logic                      i_r_done,
    input  logic                      i_blk_rdy,
    output logic [PW-1:0]             o_port,
    output logic                      o_port_vld,
    output logic [BLK_ADDR_WIDTH-1:0] o_blk_addr,
    output logic                      o_blk_addr_vld,
    output logic                      o_blk_first,
    output logic                      o_last_blk_vld,
    output logic [TIMES_WIDTH-1:0]    o_last_r_times,
    output logic                      o_len_info_vld,
    output logic                      o_single,
    output logic                      o_pkt_done,
    output logic                      o_busy,
    output logic                      o_addr_ovf,
    output logic                      o_len_err
);

    localparam int TOT_W   = LEN_WIDTH + 1;
    localparam int BLK_SH  = $clog2(BLK_BYTES);
    localparam int WORD_SH = $clog2(WORD_BYTES);

    typedef enum logic [2:0] {
        IDLE,
        PORT,
        ADDR_WAIT,
        ISSUE,
        LEN_WAIT,
        RD_WAIT,
        DONE
    } state_t;

    state_t                      state_q;
    state_t                      state_nxt;
    logic                        hold_vld;
    logic [BLK_ADDR_WIDTH-1:0]   hold_addr;
    logic                        first_q;
    logic [TOT_W-1:0]            rem_cnt;
    logic [TIMES_WIDTH-1:0]      lrt_q;

    logic                        port_acc;
    logic                        enter_issue;
    logic                        req_acc;
    logic                        len_fire;
    logic                        last_req;
    logic [TOT_W-1:0]            total;
    logic [TOT_W-1:0]            nblk;
    logic [TIMES_WIDTH-1:0]      lrt_calc;

    // Total bytes in memory: header plus payload, one bit wider than i_len.
    function automatic logic [TOT_W-1:0] calc_total(input logic [LEN_WIDTH-1:0] len);
        return {1'b0, len} + TOT_W'(HDR_BYTES);
    endfunction

    // Blocks occupied: ceil(total / BLK_BYTES). The extra bit absorbs the round-up add.
    function automatic logic [TOT_W-1:0] calc_nblk(input logic [TOT_W-1:0] tot);
        logic [TOT_W:0] sum;
        sum = {1'b0, tot} + (TOT_W + 1)'(BLK_BYTES - 1);
        return TOT_W'(sum >> BLK_SH);
    endfunction

    // Words in the last block minus one. A remainder of zero means the last block is full.
    function automatic logic [TIMES_WIDTH-1:0] calc_lrt(input logic [BLK_SH-1:0] rem);
        logic [BLK_SH:0] r;
        r = {1'b0, rem};
        if (r == '0) begin
            r = (BLK_SH + 1)'(BLK_BYTES);
        end
        return TIMES_WIDTH'((r - 1'b1) >> WORD_SH);
    endfunction

    assign total    = calc_total(i_len);
    assign nblk     = calc_nblk(total);
    assign lrt_calc = calc_lrt(total[BLK_SH-1:0]);

    assign port_acc    = (state_q == IDLE) && i_port_vld;
    assign enter_issue = (state_q == ADDR_WAIT) && hold_vld;
    // o_blk_addr_vld is always high while in ISSUE, so ready alone completes the handshake.
    assign req_acc     = (state_q == ISSUE) && i_blk_rdy;
    assign len_fire    = (state_q == LEN_WAIT) && i_len_vld;
    assign last_req    = !first_q && (rem_cnt == TOT_W'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:      if (i_port_vld) state_nxt = PORT;
            PORT:      state_nxt = ADDR_WAIT;
            ADDR_WAIT: if (hold_vld) state_nxt = ISSUE;
            ISSUE:     if (i_blk_rdy) state_nxt = first_q ? LEN_WAIT : RD_WAIT;
            LEN_WAIT:  if (i_len_vld) state_nxt = RD_WAIT;
            RD_WAIT:   if (i_r_done) state_nxt = (rem_cnt == '0) ? DONE : ADDR_WAIT;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Address holder, first-block flag, remaining-block counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_vld  <= 1'b0;
            hold_addr <= '0;
            first_q   <= 1'b0;
            rem_cnt   <= '0;
            lrt_q     <= '0;
        end else begin
            if (state_q == DONE) begin
                hold_vld  <= 1'b0;
                hold_addr <= '0;
            end else if (req_acc) begin
                hold_vld <= 1'b0;
            end else if ((state_q != IDLE) && i_blk_addr_vld && !hold_vld) begin
                hold_vld  <= 1'b1;
                hold_addr <= i_blk_addr;
            end

            if (port_acc) begin
                first_q <= 1'b1;
            end else if (req_acc) begin
                first_q <= 1'b0;
            end

            if (state_q == DONE) begin
                rem_cnt <= '0;
                lrt_q   <= '0;
            end else if (len_fire) begin
                rem_cnt <= nblk - 1'b1;
                lrt_q   <= lrt_calc;
            end else if (req_acc && !first_q && (rem_cnt != '0)) begin
                rem_cnt <= rem_cnt - 1'b1;
            end
        end
    end

    // Registered outputs. Request fields load on entry to ISSUE and hold until acceptance.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_port         <= '0;
            o_port_vld     <= 1'b0;
            o_blk_addr     <= '0;
            o_blk_addr_vld <= 1'b0;
            o_blk_first    <= 1'b0;
            o_last_blk_vld <= 1'b0;
            o_last_r_times <= '0;
            o_len_info_vld <= 1'b0;
            o_single       <= 1'b0;
            o_pkt_done     <= 1'b0;
            o_busy         <= 1'b0;
            o_addr_ovf     <= 1'b0;
            o_len_err      <= 1'b0;
        end else begin
            o_port_vld <= port_acc;
            if (port_acc) begin
                o_port <= i_port;
            end

            o_blk_addr_vld <= (state_nxt == ISSUE);
            if (enter_issue) begin
                o_blk_addr     <= hold_addr;
                o_blk_first    <= first_q;
                o_last_blk_vld <= last_req;
            end else if (state_nxt != ISSUE) begin
                o_blk_addr     <= '0;
                o_blk_first    <= 1'b0;
                o_last_blk_vld <= 1'b0;
            end

            if (len_fire) begin
                o_last_r_times <= lrt_calc;
            end else if (enter_issue) begin
                o_last_r_times <= last_req ? lrt_q : '0;
            end else if (state_nxt != ISSUE) begin
                o_last_r_times <= '0;
            end

            o_len_info_vld <= len_fire;
            o_single       <= len_fire && (nblk == TOT_W'(1));
            o_len_err      <= len_fire && (i_len == '0);
            o_pkt_done     <= (state_nxt == DONE);
            o_busy         <= (state_nxt != IDLE);
            o_addr_ovf     <= (state_q != IDLE) && i_blk_addr_vld && hold_vld;
        end
    end

endmodule

// File: tb/tb_output_blk_ctrl.sv
module tb_output_blk_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic [3:0] i_port = '0;
    logic       i_port_vld = 1'b0;
    logic [9:0] i_blk_addr = '0;
    logic       i_blk_addr_vld = 1'b0;
    logic [9:0] i_len = '0;
    logic       i_len_vld = 1'b0;
    logic       i_r_done = 1'b0;
    logic       i_blk_rdy = 1'b0;
    logic [3:0] o_port;
    logic       o_port_vld;
    logic [9:0] o_blk_addr;
    logic       o_blk_addr_vld;
    logic       o_blk_first;
    logic       o_last_blk_vld;
    logic [3:0] o_last_r_times;
    logic       o_len_info_vld;
    logic       o_single;
    logic       o_pkt_done;
    logic       o_busy;
    logic       o_addr_ovf;
    logic       o_len_err;

    int checks = 0;
    int errors = 0;
    int hi = 0;

    output_blk_ctrl dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_port         (i_port),
        .i_port_vld     (i_port_vld),
        .i_blk_addr     (i_blk_addr),
        .i_blk_addr_vld (i_blk_addr_vld),
        .i_len          (i_len),
        .i_len_vld      (i_len_vld),
        .i_r_done       (i_r_done),
        .i_blk_rdy      (i_blk_rdy),
        .o_port         (o_port),
        .o_port_vld     (o_port_vld),
        .o_blk_addr     (o_blk_addr),
        .o_blk_addr_vld (o_blk_addr_vld),
        .o_blk_first    (o_blk_first),
        .o_last_blk_vld (o_last_blk_vld),
        .o_last_r_times (o_last_r_times),
        .o_len_info_vld (o_len_info_vld),
        .o_single       (o_single),
        .o_pkt_done     (o_pkt_done),
        .o_busy         (o_busy),
        .o_addr_ovf     (o_addr_ovf),
        .o_len_err      (o_len_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pkt(input string tag, input logic [3:0] p);
        i_port = p;
        i_port_vld = 1'b1;
        tick();
        i_port_vld = 1'b0;
        check({tag, "_port_vld"}, 32'(o_port_vld), 32'd1);
        check({tag, "_port"}, 32'(o_port), 32'(p));
        check({tag, "_busy"}, 32'(o_busy), 32'd1);
    endtask

    task automatic feed_addr(input logic [9:0] a);
        i_blk_addr = a;
        i_blk_addr_vld = 1'b1;
        tick();
        i_blk_addr_vld = 1'b0;
    endtask

    task automatic rdone();
        i_r_done = 1'b1;
        tick();
        i_r_done = 1'b0;
    endtask

    task automatic take_req(input string tag, input logic [9:0] a, input logic f,
                            input logic l, input logic [3:0] lrt);
        int n = 0;
        while (!o_blk_addr_vld && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_req_vld"}, 32'(o_blk_addr_vld), 32'd1);
        check({tag, "_addr"}, 32'(o_blk_addr), 32'(a));
        check({tag, "_first"}, 32'(o_blk_first), 32'(f));
        check({tag, "_last"}, 32'(o_last_blk_vld), 32'(l));
        check({tag, "_lrt"}, 32'(o_last_r_times), 32'(lrt));
        i_blk_rdy = 1'b1;
        tick();
        i_blk_rdy = 1'b0;
        check({tag, "_req_drop"}, 32'(o_blk_addr_vld), 32'd0);
    endtask

    task automatic give_len(input string tag, input logic [9:0] len, input logic single,
                            input logic [3:0] lrt, input logic err);
        i_len = len;
        i_len_vld = 1'b1;
        tick();
        i_len_vld = 1'b0;
        check({tag, "_info_vld"}, 32'(o_len_info_vld), 32'd1);
        check({tag, "_single"}, 32'(o_single), 32'(single));
        check({tag, "_info_lrt"}, 32'(o_last_r_times), 32'(lrt));
        check({tag, "_len_err"}, 32'(o_len_err), 32'(err));
    endtask

    task automatic finish_pkt(input string tag);
        rdone();
        check({tag, "_done"}, 32'(o_pkt_done), 32'd1);
        tick();
        check({tag, "_done_clr"}, 32'(o_pkt_done), 32'd0);
        check({tag, "_idle"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_port", 32'(o_port), 32'd0);
        check("rst_req", 32'(o_blk_addr_vld), 32'd0);
        i_rst_n = 1'b1;
        tick();

        // Single block: T = 64, full last block
        start_pkt("p1", 4'd3);
        feed_addr(10'h010);
        check("p1_port_pulse", 32'(o_port_vld), 32'd0);
        take_req("p1b1", 10'h010, 1'b1, 1'b0, 4'd0);
        give_len("p1", 10'd60, 1'b1, 4'd15, 1'b0);
        tick();
        check("p1_info_clr", 32'(o_len_info_vld), 32'd0);
        check("p1_lrt_clr", 32'(o_last_r_times), 32'd0);
        check("p1_no_last", 32'(o_last_blk_vld), 32'd0);
        finish_pkt("p1");

        // Two blocks: T = 65, last block holds one word
        start_pkt("p2", 4'd5);
        feed_addr(10'h010);
        take_req("p2b1", 10'h010, 1'b1, 1'b0, 4'd0);
        give_len("p2", 10'd61, 1'b0, 4'd0, 1'b0);
        feed_addr(10'h022);
        rdone();
        check("p2_not_done", 32'(o_pkt_done), 32'd0);
        take_req("p2b2", 10'h022, 1'b0, 1'b1, 4'd0);
        finish_pkt("p2");

        // Four blocks: T = 204, last block 12 bytes; stall and overflow on block 3
        start_pkt("p3", 4'd9);
        feed_addr(10'h100);
        take_req("p3b1", 10'h100, 1'b1, 1'b0, 4'd0);
        give_len("p3", 10'd200, 1'b0, 4'd2, 1'b0);
        check("p3_cnt3", 32'(dut.rem_cnt), 32'd3);
        feed_addr(10'h101);
        rdone();
        take_req("p3b2", 10'h101, 1'b0, 1'b0, 4'd0);
        check("p3_cnt2", 32'(dut.rem_cnt), 32'd2);
        feed_addr(10'h102);
        rdone();
        tick();
        hi = 0;
        if (o_blk_addr_vld && o_blk_addr == 10'h102) hi++;
        check("p3b3_last", 32'(o_last_blk_vld), 32'd0);
        i_blk_addr = 10'h1ff;
        i_blk_addr_vld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            i_blk_addr_vld = 1'b0;
            if (o_blk_addr_vld && o_blk_addr == 10'h102) hi++;
            if (k == 0) check("p3_ovf", 32'(o_addr_ovf), 32'd1);
            if (k == 1) check("p3_ovf_clr", 32'(o_addr_ovf), 32'd0);
        end
        check("p3_stall_cycles", 32'(hi), 32'd6);
        i_blk_rdy = 1'b1;
        tick();
        i_blk_rdy = 1'b0;
        check("p3b3_req_drop", 32'(o_blk_addr_vld), 32'd0);
        check("p3_cnt1", 32'(dut.rem_cnt), 32'd1);
        feed_addr(10'h103);
        rdone();
        check("p3_not_done", 32'(o_pkt_done), 32'd0);
        take_req("p3b4", 10'h103, 1'b0, 1'b1, 4'd2);
        finish_pkt("p3");

        // Ignored port strobe while busy, zero-length packet
        start_pkt("p4", 4'd6);
        feed_addr(10'h050);
        take_req("p4b1", 10'h050, 1'b1, 1'b0, 4'd0);
        i_port = 4'd12;
        i_port_vld = 1'b1;
        tick();
        i_port_vld = 1'b0;
        check("p4_ign_vld", 32'(o_port_vld), 32'd0);
        check("p4_ign_port", 32'(o_port), 32'd6);
        give_len("p4", 10'd0, 1'b1, 4'd0, 1'b1);
        tick();
        check("p4_err_clr", 32'(o_len_err), 32'd0);
        finish_pkt("p4");

        // Reset during block 2 read, then a clean packet on port 7
        start_pkt("p5", 4'd2);
        feed_addr(10'h030);
        take_req("p5b1", 10'h030, 1'b1, 1'b0, 4'd0);
        give_len("p5", 10'd100, 1'b0, 4'd9, 1'b0);
        feed_addr(10'h031);
        rdone();
        take_req("p5b2", 10'h031, 1'b0, 1'b1, 4'd9);
        feed_addr(10'h032);
        check("p5_busy", 32'(o_busy), 32'd1);
        i_rst_n = 1'b0;
        #1;
        check("p5_rst_busy", 32'(o_busy), 32'd0);
        check("p5_rst_port", 32'(o_port), 32'd0);
        tick();
        check("p5_rst_busy2", 32'(o_busy), 32'd0);
        check("p5_rst_cnt", 32'(dut.rem_cnt), 32'd0);
        i_rst_n = 1'b1;
        tick();
        start_pkt("p6", 4'd7);
        tick();
        tick();
        check("p6_holder_clear", 32'(o_blk_addr_vld), 32'd0);
        feed_addr(10'h040);
        take_req("p6b1", 10'h040, 1'b1, 1'b0, 4'd0);
        give_len("p6", 10'd60, 1'b1, 4'd15, 1'b0);
        finish_pkt("p6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
